// File: rtl/lcd_write_sequencer.sv
// HD44780-style 8-bit LCD write sequencer: power-up wait, fixed init sequence,
// then valid/ready byte writes with enable pulse and post-write settle timing.
module lcd_write_sequencer #(
  parameter int POWERUP_CYC = 750000,
  parameter int E_PULSE_CYC = 25,
  parameter int SETTLE_CYC  = 2500,
  parameter int CLEAR_CYC   = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;

  localparam int MAX_AB  = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
  localparam int MAX_CD  = (SETTLE_CYC > CLEAR_CYC) ? SETTLE_CYC : CLEAR_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PWR_LD   = cnt_t'(POWERUP_CYC - 1);
  localparam cnt_t PULSE_LD = cnt_t'(E_PULSE_CYC - 1);
  localparam cnt_t SET_LD   = cnt_t'(SETTLE_CYC - 1);
  localparam cnt_t CLR_LD   = cnt_t'(CLEAR_CYC - 1);
  localparam logic [2:0] INIT_LAST = 3'd4;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    init_rom = 8'h38;
      3'd1:    init_rom = 8'h0C;
      3'd2:    init_rom = 8'h06;
      3'd3:    init_rom = 8'h01;
      default: init_rom = 8'h80;
    endcase
  endfunction

  logic [2:0] state;
  logic [2:0] init_idx;
  cnt_t       cnt;
  logic       is_clear;
  cnt_t       wait_ld;
  logic       last_write;

  assign is_clear   = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02));
  assign wait_ld    = is_clear ? CLR_LD : SET_LD;
  // A write that hands over to IDLE spends its final wait cycle in IDLE, so the
  // next acceptance edge lands exactly one write period after this one started.
  assign last_write = init_done || (init_idx == INIT_LAST);

  // NOTE: every register here is state, so all assignments are non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWRUP;
      init_idx  <= 3'd0;
      cnt       <= PWR_LD;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        S_PWRUP: begin
          if (cnt == '0) begin
            state    <= S_SETUP;
            lcd_rs   <= 1'b0;
            lcd_data <= init_rom(3'd0);
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        S_SETUP: begin
          state <= S_PULSE;
          lcd_e <= 1'b1;
          cnt   <= PULSE_LD;
        end

        S_PULSE: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            if (last_write && (wait_ld == '0)) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              init_done <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= last_write ? (wait_ld - cnt_t'(1)) : wait_ld;
            end
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        S_WAIT: begin
          if (cnt == '0) begin
            if (last_write) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              init_done <= 1'b1;
            end else begin
              state    <= S_SETUP;
              init_idx <= init_idx + 3'd1;
              lcd_rs   <= 1'b0;
              lcd_data <= init_rom(init_idx + 3'd1);
            end
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        S_IDLE: begin
          if (req_valid) begin
            state     <= S_SETUP;
            lcd_rs    <= req_rs;
            lcd_data  <= req_data;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end

        default: begin
          state     <= S_PWRUP;
          cnt       <= PWR_LD;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Self-checking bench for lcd_write_sequencer: scoreboard of expected bus writes
// (init ROM plus accepted requests) compared at each lcd_e strobe.
module tb_lcd_write_sequencer;

  localparam int P = 10;
  localparam int E = 3;
  localparam int S = 5;
  localparam int C = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       lcd_e;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic       init_done;
  logic       busy;

  lcd_write_sequencer #(
    .POWERUP_CYC(P),
    .E_PULSE_CYC(E),
    .SETTLE_CYC (S),
    .CLEAR_CYC  (C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_ready(req_ready),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .init_done(init_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   cyc;
  int   exp_ready;
  int   hi_cnt;
  logic prev_e;
  logic prev_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int period_of(input logic rs, input logic [7:0] d);
    return 1 + E + ((!rs && (d == 8'h01 || d == 8'h02)) ? C : S);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: everything sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e   = 1'b0;
      prev_rdy = 1'b0;
      hi_cnt   = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        if (q.size() == 0) begin
          check("spurious_strobe", 1, 0);
        end else begin
          cur = q.pop_front();
          check("bus_at_rise", {lcd_rs, lcd_data}, {cur.rs, cur.data});
          check("rise_cyc", cyc, cur.rise);
        end
        hi_cnt = 1;
      end else if (lcd_e) begin
        hi_cnt++;
      end
      if (!lcd_e && prev_e) begin
        check("e_width", hi_cnt, E);
        check("bus_hold", {lcd_rs, lcd_data}, {cur.rs, cur.data});
      end
      if (req_ready && !prev_rdy) begin
        check("ready_cyc", cyc, exp_ready);
        check("init_done_w_ready", init_done, 1);
      end
      if (req_valid && req_ready) begin
        q.push_back('{rs: req_rs, data: req_data, rise: cyc + 2});
        exp_ready = cyc + period_of(req_rs, req_data);
      end
      prev_e   = lcd_e;
      prev_rdy = req_ready;
    end
  end

  task automatic do_reset();
    logic [7:0] rom [5];
    int         rise;
    rom = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    q.delete();
    rise = P + 1;
    for (int i = 0; i < 5; i++) begin
      q.push_back('{rs: 1'b0, data: rom[i], rise: rise});
      exp_ready = rise - 1 + period_of(1'b0, rom[i]) - 1;
      rise += period_of(1'b0, rom[i]);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit drop, output int acc);
    bit got;
    got = 0;
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      check("send_timeout", 0, 1);
      acc = -1;
      req_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      @(posedge clk);
      #1;
      if (drop) req_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    bit got;
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) check("ready_timeout", 0, 1);
  endtask

  initial begin
    int a0, a1, a2, a3, a4, a5;
    bit seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;
    #12;
    check("rst_lcd_e", lcd_e, 0);
    check("rst_bus", {lcd_rs, lcd_data}, 9'h000);
    check("rst_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 1);

    // Request held throughout init must be ignored until ready rises.
    req_rs    = 1'b1;
    req_data  = 8'h30;
    req_valid = 1'b1;
    do_reset();
    send(1'b1, 8'h30, 1'b0, a0);
    check("first_accept", a0, P + 9 + 9 + 9 + 24 + 9);
    send(1'b1, 8'h31, 1'b1, a1);
    check("b2b_gap", a1 - a0, 9);

    repeat (4) @(posedge clk);
    #1;
    send(1'b1, 8'h41, 1'b1, a2);
    send(1'b0, 8'h01, 1'b1, a3);
    check("char_gap", a3 - a2, 9);
    send(1'b1, 8'h01, 1'b1, a4);
    check("clear_gap", a4 - a3, 24);
    send(1'b0, 8'h02, 1'b1, a5);
    check("rs1_01_gap", a5 - a4, 9);
    send(1'b1, 8'h42, 1'b1, a0);
    check("home_gap", a0 - a5, 24);
    wait_ready();

    // Reset while the enable strobe is high.
    send(1'b1, 8'h55, 1'b1, a1);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (lcd_e) seen = 1;
    end
    check("saw_e_before_rst", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_lcd_e", lcd_e, 0);
    check("async_init_done", init_done, 0);
    check("async_ready", req_ready, 0);
    check("async_busy", busy, 1);
    check("q_empty_at_rst", q.size(), 0);
    do_reset();
    wait_ready();
    check("init_replayed", q.size(), 0);
    check("init_done_after", init_done, 1);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Sequencer for a character LCD (HD44780-style, 8-bit bus) that owns the `lcd_e`/`lcd_rs`/`lcd_data` pins. After reset it performs the power-up wait and the fixed init command sequence by itself. It then accepts byte writes (command or character) from a single requester through a valid/ready handshake, and generates the enable pulse and post-write settle time for each write. It replaces free-running delay counters in display front-ends: value formatters such as the hex/ASCII converter feeding the adder result push characters through this block.

## Interface

Parameters:
- `POWERUP_CYC`, default 750000: cycles of idle bus after reset release (15 ms at 50 MHz).
- `E_PULSE_CYC`, default 25: cycles `lcd_e` is held high per write (500 ns).
- `SETTLE_CYC`, default 2500: wait after the `lcd_e` fall for normal writes (50 us).
- `CLEAR_CYC`, default 82000: wait after the `lcd_e` fall for clear/home commands (1.64 ms).
- All parameters must be ≥ 1. The shared down-counter is sized to $clog2 of the largest parameter.

Ports:
- `clk`, input, 1: single clock; every flop is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: a write request is present.
- `req_rs`, input, 1: 0 = command, 1 = character data.
- `req_data`, input, 8: byte to write.
- `req_ready`, output, 1: the block can accept a request this cycle.
- `lcd_e`, output, 1: LCD enable strobe.
- `lcd_rs`, output, 1: LCD register select.
- `lcd_data`, output, 8: LCD data bus.
- `init_done`, output, 1: the init sequence has completed.
- `busy`, output, 1: high in every state except IDLE.

## Operation

- States: PWRUP, SETUP, PULSE, WAIT, IDLE.
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_data`=0x00, `req_ready`=0, `init_done`=0, `busy`=1, state=PWRUP, init index=0.
- PWRUP: counts `POWERUP_CYC` cycles with all outputs at their reset values. On expiry it loads init entry 0 and goes to SETUP.
- Init ROM, all writes with `rs`=0: 0x38, 0x0C, 0x06, 0x01, 0x80.
- Write cycle (init and user writes are identical):
  - SETUP: `lcd_rs` and `lcd_data` are already registered; `lcd_e`=0 for 1 cycle.
  - PULSE: `lcd_e`=1 for `E_PULSE_CYC` cycles.
  - WAIT: `lcd_e`=0 for the wait count.
  - Wait count is `CLEAR_CYC` when `rs`=0 and data is 0x01 or 0x02; otherwise it is `SETTLE_CYC`.
- After WAIT:
  - If an init entry remains, load the next entry and go to SETUP.
  - After the last init entry, set `init_done`=1, which stays set until reset. Go to IDLE.
  - After a user write, go to IDLE.
- IDLE:
  - `req_ready`=1 and `busy`=0.
  - Acceptance happens on any edge where `req_valid && req_ready`. On that edge, `lcd_rs` ← `req_rs`, `lcd_data` ← `req_data`, and the state goes to SETUP.
- `lcd_rs` and `lcd_data` stay stable from SETUP until the next load. They are never changed while `lcd_e`=1 or during WAIT.
- `req_ready` is a registered function of the state: 1 only in IDLE, so it is never high during PWRUP or init.
- Changes to the request inputs after acceptance have no effect. `req_valid` while `req_ready`=0 is ignored, not queued.

## Timing

- Acceptance at edge k:
  - `lcd_data`/`lcd_rs` are valid from k.
  - `lcd_e` rises at k+1 and falls at k+1+`E_PULSE_CYC`.
  - `req_ready` returns high at k+1+`E_PULSE_CYC`+W, where W is the wait count.
- Write period is 1+`E_PULSE_CYC`+W cycles.
- Back-to-back: if `req_valid` is held, the next acceptance occurs on the first IDLE edge, with no extra bubble.
- Init timing:
  - The first SETUP starts `POWERUP_CYC` cycles after reset release.
  - `init_done` and `req_ready` rise together after 5 write periods, one of which uses `CLEAR_CYC` (the 0x01 write).
- Reset asserted mid-operation: all outputs return to reset values asynchronously, including `lcd_e` dropping immediately. After release the full PWRUP and init sequence repeats.

## Test plan

Use overrides `POWERUP_CYC`=10, `E_PULSE_CYC`=3, `SETTLE_CYC`=5, `CLEAR_CYC`=20.

- **Reset and init.** Release `rst_n`.
  - `lcd_e`=0 for 10 cycles.
  - Then 5 strobes of 3 cycles each, with `rs`=0 and data 0x38, 0x0C, 0x06, 0x01, 0x80.
  - The gap after 0x01 is 20 cycles; the others are 5.
  - `init_done` and `req_ready` rise together.
- **Character write.** After init, pulse `req_valid` for 1 cycle with `rs`=1, data 0x41.
  - `lcd_rs`=1 and `lcd_data`=0x41 at acceptance.
  - `lcd_e` high exactly 3 cycles starting 1 cycle later.
  - `req_ready` back high 9 cycles after acceptance.
- **Back-to-back.** Hold `req_valid`, presenting 0x30 then 0x31 (`rs`=1).
  - Accepts are exactly 9 cycles apart.
  - Both bytes appear on the bus; none dropped or duplicated.
- **Clear wait.** Write `rs`=0, data 0x01: ready returns after 1+3+20=24 cycles. Write `rs`=1, data 0x01: ready returns after 9 cycles.
- **Ignored requests.** Drive `req_valid`=1 throughout init. Nothing is accepted until `init_done`=1, and the first accept happens on the cycle `req_ready` rises.
- **Reset during write.** Assert `rst_n`=0 while `lcd_e`=1.
  - `lcd_e`, `init_done`, and `req_ready` go to 0 without waiting for a clock edge.
  - After release, the full 10-cycle PWRUP and 5-command init repeat.
